decode_ctrl_seq: RTL
====================

# decode_ctrl_seq

Registered decode stage for the 16-bit RISC pipeline: turns a fetched instruction into EX/M/WB control words and presents them to the execute stage through a valid/ready handshake. It is the successor to the combinational decoder. It adds the following:
- a pipeline register with backpressure and flush;
- parametrised widths;
- micro-op expansion of LM/SM into one register transfer per set bit of the register mask.

## Interface
Parameters:
- INST_W, 16, instruction width; opcode is Inst[INST_W-1:INST_W-4]
- NREG, 8, architectural registers; LM/SM mask is Inst[NREG-1:0]
- REG_W, 3, register index width, equal to clog2(NREG)
- EX_W, 9, execute control word width
- M_W, 3, memory control word width
- WB_W, 3, writeback control word width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  kill the in-flight and pending micro-ops (branch/jump redirect)
- in_valid  in  1  instruction available
- in_ready  out  1  decode accepts the instruction this cycle
- in_inst  in  INST_W  instruction
- out_valid  out  1  control bundle valid
- out_ready  in  1  execute stage consumes the bundle
- out_inst  out  INST_W  instruction carried with the bundle
- out_ex  out  EX_W  execute controls
- out_m  out  M_W  memory controls
- out_wb  out  WB_W  writeback controls
- out_reg  out  REG_W  LM/SM register index for this micro-op; 0 otherwise
- out_first  out  1  first micro-op of an instruction
- out_last  out  1  last micro-op of an instruction
- busy  out  1  LM/SM expansion in progress

## Operation
Control words, listed as opcode: EX / M / WB:
- ADD 0000: 001110010 / 000 / 101
- ADI 0001: 011110000 / 000 / 101
- NAND 0010: 001010110 / 000 / 101
- LHI 0011: 100000000 / 000 / 111
- LW 0100: 100000000 / 010 / 001
- SW 0101: 000000000 / 001 / 000
- LM 0110: 110000000 / 110 / 001
- SM 0111: 110000000 / 001 / 000
- JAL 1000: 100000000 / 000 / 011
- JLR 1001: 100000000 / 000 / 011
- BEQ 1100: 001001010 / 000 / 000
- All other opcodes, and in_inst == 0: all-zero control words, still passed through as a valid bundle.

Non-LM/SM instructions:
- Produce one bundle with out_first = out_last = 1 and out_reg = 0.

LM/SM instructions:
- Produce one bundle per set bit of the mask, in ascending index order.
- out_reg carries the bit index; all bundles carry the same out_inst, EX, M and WB.
- out_first is set on the first bundle only; out_last on the final bundle only.
- Mask 0: one bundle with all-zero controls, out_first = out_last = 1.

State machine:
- IDLE: in_ready = rst_n & !flush & (!out_valid | out_ready).
  - On accept, load the output register and set out_valid.
  - For LM/SM whose mask has more than one set bit: store the remaining mask (lowest set bit cleared) and go to SEQ.
- SEQ: in_ready = 0, busy = 1.
  - On each out_valid & out_ready, load the next lowest set bit and clear it from the remaining mask.
  - When the loaded bit was the last one, set out_last and return to IDLE.
- With no accept and out_ready high, out_valid drops to 0.

Flush:
- Synchronous, with priority over every other event in that cycle.
- Clears out_valid and the remaining mask, returns to IDLE, and accepts no input that cycle.

## Timing
- Reset, and the cycle after flush: out_valid = 0, busy = 0, all data outputs 0, state IDLE.
- Latency: in_valid & in_ready at edge N gives out_valid from N+1.
- Throughput:
  - 1 bundle per cycle for non-LM/SM instructions when out_ready is held high.
  - An LM/SM with k set bits occupies k consecutive cycles.
- Outputs hold stable while out_valid & !out_ready.
- in_ready is combinational from out_valid, out_ready, flush, state and rst_n; it has no path from in_valid.
- Reset asserted during SEQ abandons the sequence; no further micro-ops are issued.

## Structure
- decode_pkg holds:
  - opcode constants;
  - the per-opcode EX/M/WB constants listed above;
  - the state enum for IDLE and SEQ.
- Sub-module mask_prienc (parametrised on NREG):
  - combinational lowest-set-bit finder;
  - outputs are the index, a found flag, the mask with that bit cleared, and a flag for "one bit remaining";
  - instantiated once, on the pending or incoming mask.

## Test plan
- Reset, then stream ADD 0x0123, ADI 0x1234, LW 0x4567 with out_ready = 1 → three consecutive bundles starting the cycle after the first accept; EX 001110010, 011110000, 100000000; WB 101, 101, 001; out_first = out_last = 1 on each.
- LM 0x60A5 (mask 10100101) → out_reg 0, 2, 5, 7 on four cycles; M = 110 on all; out_first only on reg 0, out_last only on reg 7; in_ready = 0 and busy = 1 until the last bundle is loaded.
- SM 0x7000 (mask 0) → a single bundle with all-zero controls, out_first = out_last = 1, busy stays 0.
- Hold out_ready = 0 for 3 cycles during SM 0x7003 → out_reg stays 0 and all outputs stay stable; after release, reg 1 follows with out_last = 1.
- Assert flush while issuing reg 2 of LM 0x60FF → out_valid = 0 next cycle, busy = 0, in_ready = 1; the next instruction (NAND 0x2000) decodes with EX 001010110.
- Drive in_inst 0x0000 and opcode 1111 → valid bundles with all-zero EX/M/WB.

Source files
------------

// File: rtl/decode_pkg.sv
// Decode stage package: opcodes, control-word table, sequencer states.
// Shared by the registered decoder and its LM/SM mask sequencer.
package decode_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LHI  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_LM   = 4'b0110;
  localparam logic [3:0] OP_SM   = 4'b0111;
  localparam logic [3:0] OP_JAL  = 4'b1000;
  localparam logic [3:0] OP_JLR  = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1100;

  localparam logic [8:0] EX_ADD  = 9'b001110010;
  localparam logic [8:0] EX_ADI  = 9'b011110000;
  localparam logic [8:0] EX_NAND = 9'b001010110;
  localparam logic [8:0] EX_IMM  = 9'b100000000;
  localparam logic [8:0] EX_MULT = 9'b110000000;
  localparam logic [8:0] EX_BEQ  = 9'b001001010;

  typedef struct packed {
    logic [8:0] ex;
    logic [2:0] m;
    logic [2:0] wb;
  } ctrl_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEQ  = 1'b1
  } state_e;

  function automatic ctrl_t decode_op(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    unique case (op)
      OP_ADD:  c = '{EX_ADD,  3'b000, 3'b101};
      OP_ADI:  c = '{EX_ADI,  3'b000, 3'b101};
      OP_NAND: c = '{EX_NAND, 3'b000, 3'b101};
      OP_LHI:  c = '{EX_IMM,  3'b000, 3'b111};
      OP_LW:   c = '{EX_IMM,  3'b010, 3'b001};
      OP_SW:   c = '{9'b0,    3'b001, 3'b000};
      OP_LM:   c = '{EX_MULT, 3'b110, 3'b001};
      OP_SM:   c = '{EX_MULT, 3'b001, 3'b000};
      OP_JAL:  c = '{EX_IMM,  3'b000, 3'b011};
      OP_JLR:  c = '{EX_IMM,  3'b000, 3'b011};
      OP_BEQ:  c = '{EX_BEQ,  3'b000, 3'b000};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_ctrl_seq_mask_prienc.sv
// Lowest-set-bit finder for the LM/SM register mask.
// Also returns the mask with that bit cleared and a last-bit flag.
module mask_prienc #(
  parameter int NREG  = 8,
  parameter int REG_W = $clog2(NREG)
) (
  input  logic [NREG-1:0]  mask,
  output logic [REG_W-1:0] idx,
  output logic             found,
  output logic [NREG-1:0]  rest,
  output logic             one
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = REG_W'(i);
        found = 1'b1;
      end
    end
  end

  assign rest = mask & (mask - NREG'(1));
  assign one  = found & ~|rest;

endmodule

// File: rtl/decode_ctrl_seq.sv
// Registered decode stage with valid/ready output, flush,
// and LM/SM expansion into one micro-op per mask bit.
module decode_ctrl_seq #(
  parameter int INST_W = 16,
  parameter int NREG   = 8,
  parameter int REG_W  = 3,
  parameter int EX_W   = 9,
  parameter int M_W    = 3,
  parameter int WB_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [EX_W-1:0]   out_ex,
  output logic [M_W-1:0]    out_m,
  output logic [WB_W-1:0]   out_wb,
  output logic [REG_W-1:0]  out_reg,
  output logic              out_first,
  output logic              out_last,
  output logic              busy
);
  import decode_pkg::*;

  state_e           state;
  logic [NREG-1:0]  pend;
  logic [NREG-1:0]  pe_mask;
  logic [NREG-1:0]  pe_rest;
  logic [REG_W-1:0] pe_idx;
  logic             pe_found;
  logic             pe_one;
  logic [3:0]       op;
  logic             is_lmsm;
  logic             zero_ctl;
  logic             accept;
  ctrl_t            ctl;

  assign op      = in_inst[INST_W-1 -: 4];
  assign is_lmsm = (op == OP_LM) | (op == OP_SM);
  assign pe_mask = (state == S_SEQ) ? pend : in_inst[NREG-1:0];

  mask_prienc #(
    .NREG  (NREG),
    .REG_W (REG_W)
  ) u_prienc (
    .mask  (pe_mask),
    .idx   (pe_idx),
    .found (pe_found),
    .rest  (pe_rest),
    .one   (pe_one)
  );

  assign in_ready = rst_n & ~flush & (state == S_IDLE)
                  & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign busy     = (state == S_SEQ);

  // empty LM/SM mask degenerates to a no-op bundle
  assign zero_ctl = (in_inst == '0) | (is_lmsm & ~pe_found);
  assign ctl      = zero_ctl ? '0 : decode_op(op);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state     <= S_IDLE;
      pend      <= '0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_ex    <= '0;
      out_m     <= '0;
      out_wb    <= '0;
      out_reg   <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (accept) begin
        out_valid <= 1'b1;
        out_inst  <= in_inst;
        out_ex    <= EX_W'(ctl.ex);
        out_m     <= M_W'(ctl.m);
        out_wb    <= WB_W'(ctl.wb);
        out_first <= 1'b1;
        if (is_lmsm && pe_found) begin
          out_reg  <= pe_idx;
          out_last <= pe_one;
          pend     <= pe_rest;
          if (!pe_one) state <= S_SEQ;
        end else begin
          out_reg  <= '0;
          out_last <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else if (out_valid && out_ready) begin
      out_reg   <= pe_idx;
      out_first <= 1'b0;
      out_last  <= pe_one;
      pend      <= pe_rest;
      if (pe_one) state <= S_IDLE;
    end
  end

endmodule
